// File: rtl/control_fsm_if.sv
// control_fsm_if: datapath/memory handshake inputs and control strobes of the MIPS sequencer
interface control_fsm_if;
    logic [5:0] op_code;
    logic [5:0] funct;
    logic       instr_ready;
    logic       mem_ready;
    logic       instr_req;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] alu_op;
    logic       reg_dst;
    logic       branch;
    logic       jump_reg;
    logic       jump;
    logic       jal;
    logic       and_op;
    logic       mem_read;
    logic       mem_to_reg;
    logic       mem_write;
    logic       immediate;
    logic       reg_write;

    modport master (
        input  op_code, funct, instr_ready, mem_ready,
        output instr_req, ir_write, pc_write, alu_op, reg_dst, branch, jump_reg, jump, jal,
               and_op, mem_read, mem_to_reg, mem_write, immediate, reg_write
    );

    modport slave (
        output op_code, funct, instr_ready, mem_ready,
        input  instr_req, ir_write, pc_write, alu_op, reg_dst, branch, jump_reg, jump, jal,
               and_op, mem_read, mem_to_reg, mem_write, immediate, reg_write
    );
endinterface

// File: rtl/control_fsm.sv
// control_fsm: multicycle MIPS control sequencer with memory handshakes, traps and retire counter
module control_fsm #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter logic [5:0]  HALT_OPCODE = 6'h3F
) (
    input  logic                clk,
    input  logic                rst_n,
    control_fsm_if.master       bus,
    output logic                halted,
    output logic [1:0]          fault,
    output logic [31:0]         instr_count,
    output logic [2:0]          state
);
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_HALT      = 3'd6,
        S_TRAP      = 3'd7
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] FN_JR   = 6'b001000;

    state_t      cur, nxt;
    logic [5:0]  op_q, funct_q, op;
    logic [31:0] tmo_cnt;
    logic        tmo_hit, retire;
    logic [1:0]  trap_code;

    // DECODE acts on the live opcode; later phases use the copy captured in DECODE
    assign op      = (cur == S_DECODE) ? bus.op_code : op_q;
    assign tmo_hit = (MEM_TIMEOUT != 0) && (tmo_cnt == MEM_TIMEOUT - 1);
    assign halted  = (cur == S_HALT);
    assign state   = cur;

    // State, latched instruction fields, wait-cycle counter, retire counter and sticky fault code
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur         <= S_IDLE;
            op_q        <= '0;
            funct_q     <= '0;
            tmo_cnt     <= '0;
            instr_count <= '0;
            fault       <= '0;
        end else begin
            cur         <= nxt;
            if (cur == S_DECODE) begin
                op_q    <= bus.op_code;
                funct_q <= bus.funct;
            end
            tmo_cnt     <= (nxt == cur && (cur == S_FETCH || cur == S_MEMORY)) ? tmo_cnt + 32'd1 : '0;
            instr_count <= instr_count + 32'(retire);
            fault       <= fault | trap_code;
        end
    end

    // Next state, retire/trap events and all datapath strobes for the current phase
    always_comb begin
        nxt            = cur;
        retire         = 1'b0;
        trap_code      = 2'b00;
        bus.instr_req  = 1'b0;
        bus.ir_write   = 1'b0;
        bus.pc_write   = 1'b0;
        bus.alu_op     = 2'b00;
        bus.reg_dst    = 1'b0;
        bus.branch     = 1'b0;
        bus.jump_reg   = 1'b0;
        bus.jump       = 1'b0;
        bus.jal        = 1'b0;
        bus.and_op     = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.mem_write  = 1'b0;
        bus.immediate  = 1'b0;
        bus.reg_write  = 1'b0;
        case (cur)
            S_IDLE: nxt = S_FETCH;
            S_FETCH: begin
                bus.instr_req = 1'b1;
                if (bus.instr_ready) begin
                    bus.ir_write = 1'b1;
                    bus.pc_write = 1'b1;
                    nxt          = S_DECODE;
                end else if (tmo_hit) begin
                    nxt       = S_TRAP;
                    trap_code = 2'b10;
                end
            end
            S_DECODE: begin
                if (op == HALT_OPCODE) begin
                    nxt = S_HALT;
                end else if (op == OP_J || op == OP_JAL) begin
                    bus.jump      = 1'b1;
                    bus.pc_write  = 1'b1;
                    bus.jal       = (op == OP_JAL);
                    bus.reg_write = (op == OP_JAL);
                    retire        = 1'b1;
                    nxt           = S_FETCH;
                end else if (op inside {OP_R, OP_BEQ, OP_ADDI, OP_ANDI, OP_LW, OP_SW}) begin
                    nxt = S_EXECUTE;
                end else begin
                    nxt       = S_TRAP;
                    trap_code = 2'b01;
                end
            end
            S_EXECUTE: begin
                if (op == OP_BEQ) begin
                    bus.alu_op   = 2'b01;
                    bus.branch   = 1'b1;
                    bus.and_op   = 1'b1;
                    bus.pc_write = 1'b1;
                    retire       = 1'b1;
                    nxt          = S_FETCH;
                end else if (op == OP_R && funct_q == FN_JR) begin
                    bus.jump_reg = 1'b1;
                    bus.pc_write = 1'b1;
                    retire       = 1'b1;
                    nxt          = S_FETCH;
                end else if (op == OP_R) begin
                    bus.alu_op = 2'b10;
                    nxt        = S_WRITEBACK;
                end else begin
                    bus.alu_op    = (op == OP_ANDI) ? 2'b11 : 2'b00;
                    bus.immediate = 1'b1;
                    nxt           = (op == OP_LW || op == OP_SW) ? S_MEMORY : S_WRITEBACK;
                end
            end
            S_MEMORY: begin
                bus.immediate = 1'b1;
                bus.mem_read  = (op == OP_LW);
                bus.mem_write = (op == OP_SW);
                if (bus.mem_ready) begin
                    nxt    = (op == OP_LW) ? S_WRITEBACK : S_FETCH;
                    retire = (op != OP_LW);
                end else if (tmo_hit) begin
                    nxt       = S_TRAP;
                    trap_code = 2'b10;
                end
            end
            S_WRITEBACK: begin
                bus.reg_write  = 1'b1;
                bus.reg_dst    = (op == OP_R);
                bus.mem_to_reg = (op == OP_LW);
                bus.immediate  = (op != OP_R);
                retire         = 1'b1;
                nxt            = S_FETCH;
            end
            default: nxt = cur;
        endcase
    end
endmodule

// File: tb/tb_control_fsm.sv
// tb_control_fsm: randomized instruction streams checked against an instruction-level phase model
module tb_control_fsm;
    localparam int TMO = 4;
    localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3;
    localparam logic [2:0] S_MEM = 3'd4, S_WB = 3'd5, S_HALT = 3'd6, S_TRAP = 3'd7;
    localparam int K_R = 0, K_JR = 1, K_BEQ = 2, K_ADDI = 3, K_ANDI = 4, K_LW = 5;
    localparam int K_SW = 6, K_J = 7, K_JAL = 8, K_ILL = 9, K_HALT = 10;
    localparam logic [15:0] M_REQ = 16'h8000, M_IRW = 16'h4000, M_PCW = 16'h2000;
    localparam logic [15:0] M_A01 = 16'h0800, M_A10 = 16'h1000, M_A11 = 16'h1800;
    localparam logic [15:0] M_RD = 16'h0400, M_BR = 16'h0200, M_JR = 16'h0100, M_J = 16'h0080;
    localparam logic [15:0] M_JAL = 16'h0040, M_AND = 16'h0020, M_MR = 16'h0010, M_M2R = 16'h0008;
    localparam logic [15:0] M_MW = 16'h0004, M_IMM = 16'h0002, M_RW = 16'h0001;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        halted;
    logic [1:0]  fault;
    logic [31:0] instr_count;
    logic [2:0]  state;
    logic [15:0] obs;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_count = '0;
    logic [1:0]  exp_fault = '0;
    logic        exp_halt = 1'b0;
    bit          dead = 1'b0;
    logic [2:0]  dead_st = S_IDLE;
    logic [5:0]  ill_op = 6'h3E;

    control_fsm_if bus();

    control_fsm #(.MEM_TIMEOUT(TMO)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .halted(halted),
        .fault(fault),
        .instr_count(instr_count),
        .state(state)
    );

    always #5 clk = ~clk;

    assign obs = {bus.instr_req, bus.ir_write, bus.pc_write, bus.alu_op, bus.reg_dst, bus.branch,
                  bus.jump_reg, bus.jump, bus.jal, bus.and_op, bus.mem_read, bus.mem_to_reg,
                  bus.mem_write, bus.immediate, bus.reg_write};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [5:0] rnd6();
        return 6'($urandom_range(0, 63));
    endfunction

    function automatic int rnd_wait();
        return ($urandom_range(0, 11) == 0) ? 4 + $urandom_range(0, 2) : $urandom_range(0, 3);
    endfunction

    task automatic cyc(input logic [2:0] st, input logic [15:0] sv, input logic ir, input logic mr,
                       input logic [5:0] op, input logic [5:0] fn);
        @(negedge clk);
        bus.instr_ready = ir;
        bus.mem_ready   = mr;
        bus.op_code     = op;
        bus.funct       = fn;
        #1;
        check("state", 32'(state), 32'(st));
        check("strobes", 32'(obs), 32'(sv));
        check("count", instr_count, exp_count);
        check("fault", 32'(fault), 32'(exp_fault));
        check("halted", 32'(halted), 32'(exp_halt));
    endtask

    task automatic wait_phase(input logic [2:0] st, input logic [15:0] sv, input logic [15:0] rsv,
                              input int w, input bit is_mem, output bit ok);
        bit rdy;
        ok = 1'b1;
        for (int i = 0; i <= w; i++) begin
            rdy = (i == w);
            cyc(st, rdy ? (sv | rsv) : sv, is_mem ? 1'($urandom) : rdy, is_mem ? rdy : 1'($urandom),
                rnd6(), rnd6());
            if (!rdy && i == TMO - 1) begin
                exp_fault = 2'b10;
                dead      = 1'b1;
                dead_st   = S_TRAP;
                ok        = 1'b0;
                return;
            end
        end
    endtask

    task automatic run_instr(input int k, input int fw, input int mw, input bit abort);
        logic [5:0]  op, fn;
        logic [15:0] sv;
        bit          ok;
        case (k)
            K_BEQ:   op = 6'h04;
            K_ADDI:  op = 6'h08;
            K_ANDI:  op = 6'h0C;
            K_LW:    op = 6'h23;
            K_SW:    op = 6'h2B;
            K_J:     op = 6'h02;
            K_JAL:   op = 6'h03;
            K_ILL:   op = ill_op;
            K_HALT:  op = 6'h3F;
            default: op = 6'h00;
        endcase
        fn = rnd6();
        if (k == K_JR) fn = 6'h08;
        else if (k == K_R) while (fn == 6'h08) fn = rnd6();
        wait_phase(S_FETCH, M_REQ, M_IRW | M_PCW, fw, 1'b0, ok);
        if (!ok) return;
        sv = (k == K_J) ? (M_J | M_PCW) : (k == K_JAL) ? (M_J | M_JAL | M_RW | M_PCW) : 16'h0;
        cyc(S_DECODE, sv, 1'($urandom), 1'($urandom), op, fn);
        if (k == K_HALT) begin
            exp_halt = 1'b1;
            dead     = 1'b1;
            dead_st  = S_HALT;
            return;
        end
        if (k == K_ILL) begin
            exp_fault = 2'b01;
            dead      = 1'b1;
            dead_st   = S_TRAP;
            return;
        end
        if (k == K_J || k == K_JAL) begin
            exp_count++;
            return;
        end
        case (k)
            K_BEQ:   sv = M_A01 | M_BR | M_AND | M_PCW;
            K_JR:    sv = M_JR | M_PCW;
            K_R:     sv = M_A10;
            K_ANDI:  sv = M_A11 | M_IMM;
            default: sv = M_IMM;
        endcase
        cyc(S_EXEC, sv, 1'($urandom), 1'($urandom), rnd6(), rnd6());
        if (k == K_BEQ || k == K_JR) begin
            exp_count++;
            return;
        end
        if (k == K_LW || k == K_SW) begin
            sv = M_IMM | ((k == K_LW) ? M_MR : M_MW);
            if (abort) begin
                cyc(S_MEM, sv, 1'($urandom), 1'b0, rnd6(), rnd6());
                return;
            end
            wait_phase(S_MEM, sv, 16'h0, mw, 1'b1, ok);
            if (!ok) return;
            if (k == K_SW) begin
                exp_count++;
                return;
            end
        end
        sv = M_RW | ((k == K_R) ? M_RD : M_IMM) | ((k == K_LW) ? M_M2R : 16'h0);
        cyc(S_WB, sv, 1'($urandom), 1'($urandom), rnd6(), rnd6());
        exp_count++;
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) cyc(dead_st, 16'h0, 1'($urandom), 1'($urandom), rnd6(), rnd6());
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        exp_count = '0;
        exp_fault = '0;
        exp_halt  = 1'b0;
        dead      = 1'b0;
        check("rst_state", 32'(state), 32'(S_IDLE));
        check("rst_strobes", 32'(obs), 32'h0);
        check("rst_count", instr_count, 32'h0);
        check("rst_fault", 32'(fault), 32'h0);
        check("rst_halted", 32'(halted), 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("idle_state", 32'(state), 32'(S_IDLE));
        check("idle_strobes", 32'(obs), 32'h0);
    endtask

    initial begin
        int k;
        bus.instr_ready = 1'b0;
        bus.mem_ready   = 1'b0;
        bus.op_code     = '0;
        bus.funct       = '0;
        do_reset();
        run_instr(K_R, 0, 0, 1'b0);
        run_instr(K_LW, 0, 3, 1'b0);
        run_instr(K_BEQ, 0, 0, 1'b0);
        run_instr(K_JAL, 0, 0, 1'b0);
        run_instr(K_JR, 0, 0, 1'b0);
        run_instr(K_SW, 2, 1, 1'b0);
        run_instr(K_ADDI, 1, 0, 1'b0);
        run_instr(K_ANDI, 0, 0, 1'b0);
        run_instr(K_J, 0, 0, 1'b0);
        run_instr(K_R, 3, 0, 1'b0);
        ill_op = 6'h3E;
        run_instr(K_ILL, 0, 0, 1'b0);
        hold(5);
        do_reset();
        run_instr(K_R, 9, 0, 1'b0);
        hold(3);
        do_reset();
        run_instr(K_SW, 0, 9, 1'b0);
        hold(3);
        do_reset();
        run_instr(K_LW, 1, 2, 1'b1);
        do_reset();
        run_instr(K_HALT, 0, 0, 1'b0);
        hold(100);
        do_reset();
        for (int n = 0; n < 300; n++) begin
            k = $urandom_range(0, 19);
            k = (k < 4) ? K_R : (k == 4) ? K_JR : (k < 7) ? K_BEQ : (k < 9) ? K_ADDI :
                (k < 11) ? K_ANDI : (k < 14) ? K_LW : (k < 16) ? K_SW : (k == 16) ? K_J :
                (k == 17) ? K_JAL : (k == 18) ? K_ILL : K_HALT;
            do ill_op = rnd6();
            while (ill_op inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h08, 6'h0C, 6'h23, 6'h2B, 6'h3F});
            run_instr(k, rnd_wait(), rnd_wait(), 1'b0);
            if (dead) begin
                hold(3);
                do_reset();
            end
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
